nios_cpu_nios2_cpu_debug_ocimem: RTL
====================================

// Module: nios_cpu_nios2_cpu_debug_ocimem
// PURPOSE
//  Sysclk-side consumer of the debug slave's jdo/take_action_ocimem_* strobes. Owns the on-chip
//  debug (monitor) RAM and the JTAG monitor data/address registers. Arbitrates JTAG-host access
//  against the CPU's debug_mem slave port. Returns MonDReg/monitor_ready/monitor_error to the
//  debug slave TCK logic for capture.
// PARAMETERS
//  ADDR_W   8   word-address width of debug RAM (2**ADDR_W x 32 bit); legal range 4..16
// PORTS
//  clk                     in   1   system clock; sole clock
//  reset_n                 in   1   asynchronous active-low reset
//  jdo                     in   38  JTAG data out, stable while any take_* strobe is high
//  take_action_ocimem_a    in   1   1-cycle strobe: address load / optional read / flag clear
//  take_no_action_ocimem_a in   1   1-cycle strobe: read at MonAReg+1 (auto-increment read)
//  take_action_ocimem_b    in   1   1-cycle strobe: write jdo[34:3] at MonAReg, then increment
//  cpu_address             in   ADDR_W+1  word address; MSB=1 selects status register
//  cpu_read / cpu_write    in   1   Avalon-MM read/write request, held until !cpu_waitrequest
//  cpu_writedata           in   32  write data
//  cpu_byteenable          in   4   byte lanes for RAM writes (ignored for status register)
//  cpu_readdata            out  32  read data, valid when cpu_read & !cpu_waitrequest
//  cpu_waitrequest         out  1   stall
//  MonDReg                 out  32  JTAG monitor data register
//  monitor_ready           out  1   sticky flag set by CPU, cleared by JTAG
//  monitor_error           out  1   sticky flag set by CPU, cleared by JTAG
// BEHAVIOUR
//  Reset: MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, cpu_readdata=0,
//  cpu_waitrequest=1 (deasserts 1st cycle after reset release), FSM=IDLE, jtag_pend=0.
//  RAM: single-port, synchronous read, 1-cycle latency; contents not reset.
//  JTAG decode (latched into jtag_pend + op on strobe, serviced from IDLE):
//   - ocimem_a: MonAReg<=jdo[17+ADDR_W:18]. If jdo[17]=1 -> RAM read at the new address.
//     If jdo[35]=1 -> clear monitor_ready and monitor_error (same cycle as strobe).
//   - no_action_ocimem_a: MonAReg<=MonAReg+1 (mod 2**ADDR_W, wraps), then RAM read there.
//   - ocimem_b: write jdo[34:3] to RAM[MonAReg], all byte lanes; MonDReg<=jdo[34:3];
//     MonAReg<=MonAReg+1 (wraps).
//   - Strobes are mutually exclusive and spaced >=4 clk apart. A strobe during pend is an
//     error; simulation assertion only, the newer op overwrites.
//  FSM: IDLE, JRD, CRD.
//   - IDLE & jtag_pend: read op -> drive RAM addr, go JRD. Write op -> RAM write this cycle,
//     clear pend, stay IDLE.
//   - JRD: MonDReg<=RAM q, clear pend -> IDLE. MonDReg valid 2 clk after strobe (no contention).
//   - IDLE & !jtag_pend & cpu_read to RAM: drive addr, waitrequest=1, go CRD.
//   - CRD: cpu_readdata<=q, waitrequest=0 this cycle -> IDLE. Read = exactly 1 wait state.
//   - IDLE & !jtag_pend & cpu_write: RAM write with byteenable, waitrequest=0 (0 wait states).
//   - Status register (cpu_address MSB=1) is serviced in IDLE with 0 wait states:
//     read = {30'b0, monitor_error, monitor_ready}; write: wdata[0]=1 sets ready, wdata[1]=1 sets error.
//  Priority: pending JTAG op beats a new CPU request. A CPU request seen in IDLE while pend=1
//   sees waitrequest=1 until JTAG op completes. A CPU access in CRD completes before pend is served.
//  Simultaneous set (CPU status write) and clear (ocimem_a with jdo[35]) in the same cycle:
//   clear wins.
//  cpu_read and cpu_write both high: protocol error, write ignored, read serviced.
//  Async reset mid-operation aborts any access; the in-flight RAM write may or may not land.
//   The CPU must reissue.
// TESTING
//  1 ocimem_b x3 after ocimem_a(addr=0x10, jdo[17]=0) writing 0xDEADBEEF,1,2 -> RAM[0x10..0x12]
//    hold those; MonAReg=0x13.
//  2 ocimem_a(addr=0x10, jdo[17]=1), then no_action_ocimem_a -> MonDReg=0xDEADBEEF at +2 clk,
//    then 0x00000001.
//  3 MonAReg=0xFF, ocimem_b data 0x55 -> RAM[0xFF]=0x55, MonAReg wraps to 0x00.
//  4 CPU read of 0x10 -> waitrequest high exactly 1 cycle, readdata=0xDEADBEEF; CPU write with
//    byteenable=4'b0010 of 0x0000AB00 -> RAM word 0xDEADABEF.
//  5 CPU status write 0x3 -> ready=error=1. Same-cycle ocimem_a with jdo[35]=1 plus CPU write 0x1
//    -> both flags 0.
//  6 ocimem_a read strobe asserted the cycle before cpu_read -> JTAG read served first;
//    cpu_waitrequest held 2 extra cycles; both data correct.
//    Reset asserted in JRD -> all outputs at reset values.

Source files
------------

// File: rtl/nios_cpu_nios2_cpu_debug_ocimem.sv
// rtl/nios_cpu_nios2_cpu_debug_ocimem.sv - debug monitor RAM, JTAG monitor registers and
// JTAG/CPU arbitration onto a single-port synchronous RAM.
module nios_cpu_nios2_cpu_debug_ocimem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W:0]   cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, JRD, CRD} state_t;

  state_t              state_q, state_d;
  logic                init_q;
  logic                jtag_pend_q, jtag_pend_d;
  logic                jtag_wr_q, jtag_wr_d;
  logic [ADDR_W-1:0]   jtag_addr_q, jtag_addr_d;
  logic [31:0]         jtag_wdata_q, jtag_wdata_d;
  logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
  logic [31:0]         mon_d_q, mon_d_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;

  logic [31:0]         ram [0:(1<<ADDR_W)-1];
  logic [31:0]         ram_q;
  logic                ram_we;
  logic [3:0]          ram_be;
  logic [ADDR_W-1:0]   ram_addr;
  logic [31:0]         ram_wdata;

  logic                cpu_status;
  logic [ADDR_W-1:0]   mon_a_inc;
  logic                unused_jdo;

  assign cpu_status = cpu_address[ADDR_W];
  assign mon_a_inc  = mon_a_q + 1'b1;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_d      = state_q;
    jtag_pend_d  = jtag_pend_q;
    jtag_wr_d    = jtag_wr_q;
    jtag_addr_d  = jtag_addr_q;
    jtag_wdata_d = jtag_wdata_q;
    mon_a_d      = mon_a_q;
    mon_d_d      = mon_d_q;
    rdata_d      = rdata_q;
    ready_d      = ready_q;
    error_d      = error_q;
    ram_we       = 1'b0;
    ram_be       = 4'h0;
    ram_addr     = cpu_address[ADDR_W-1:0];
    ram_wdata    = cpu_writedata;
    cpu_waitrequest = 1'b1;
    cpu_readdata    = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (jtag_pend_q) begin
          ram_addr = jtag_addr_q;
          if (jtag_wr_q) begin
            ram_we      = 1'b1;
            ram_be      = 4'hf;
            ram_wdata   = jtag_wdata_q;
            jtag_pend_d = 1'b0;
          end else begin
            state_d = JRD;
          end
        end else if (init_q) begin
          cpu_waitrequest = 1'b0;
          // A simultaneous read and write is serviced as a read only.
          if (cpu_read) begin
            if (cpu_status) begin
              cpu_readdata = {30'd0, error_q, ready_q};
              rdata_d      = {30'd0, error_q, ready_q};
            end else begin
              cpu_waitrequest = 1'b1;
              state_d         = CRD;
            end
          end else if (cpu_write) begin
            if (cpu_status) begin
              ready_d = ready_q | cpu_writedata[0];
              error_d = error_q | cpu_writedata[1];
            end else begin
              ram_we = 1'b1;
              ram_be = cpu_byteenable;
            end
          end
        end
      end
      JRD: begin
        mon_d_d     = ram_q;
        jtag_pend_d = 1'b0;
        state_d     = IDLE;
      end
      CRD: begin
        cpu_waitrequest = 1'b0;
        cpu_readdata    = ram_q;
        rdata_d         = ram_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are applied last so a JTAG clear beats a same-cycle CPU set.
    if (take_action_ocimem_a) begin
      mon_a_d = jdo[17+ADDR_W:18];
      if (jdo[17]) begin
        jtag_pend_d = 1'b1;
        jtag_wr_d   = 1'b0;
        jtag_addr_d = jdo[17+ADDR_W:18];
      end
      if (jdo[35]) begin
        ready_d = 1'b0;
        error_d = 1'b0;
      end
    end else if (take_no_action_ocimem_a) begin
      mon_a_d     = mon_a_inc;
      jtag_pend_d = 1'b1;
      jtag_wr_d   = 1'b0;
      jtag_addr_d = mon_a_inc;
    end else if (take_action_ocimem_b) begin
      mon_a_d      = mon_a_inc;
      mon_d_d      = jdo[34:3];
      jtag_pend_d  = 1'b1;
      jtag_wr_d    = 1'b1;
      jtag_addr_d  = mon_a_q;
      jtag_wdata_d = jdo[34:3];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      init_q       <= 1'b0;
      jtag_pend_q  <= 1'b0;
      jtag_wr_q    <= 1'b0;
      jtag_addr_q  <= '0;
      jtag_wdata_q <= '0;
      mon_a_q      <= '0;
      mon_d_q      <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_q       <= 1'b1;
      jtag_pend_q  <= jtag_pend_d;
      jtag_wr_q    <= jtag_wr_d;
      jtag_addr_q  <= jtag_addr_d;
      jtag_wdata_q <= jtag_wdata_d;
      mon_a_q      <= mon_a_d;
      mon_d_q      <= mon_d_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    ram_q <= ram[ram_addr];
  end

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

  strobe_while_pending: assert property (@(posedge clk) disable iff (!reset_n)
    (take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b) |-> !jtag_pend_q);

endmodule
